// File: rtl/trivium_out_buffer.sv
// rtl/trivium_out_buffer.sv - elastic byte buffer between the Trivium core and its consumer
//
// Purpose:
//   Captures every encrypted byte the cipher core emits (stream/wt_sgn) and
//   presents it downstream over a first-word fall-through valid/ready port.
//   The core cannot be stalled, so an early hold-off flag asks the controller
//   to stop issuing data strobes; a byte that still arrives while the buffer is
//   full is dropped and recorded in a sticky flag and a saturating counter.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   in_data    in   [7:0] byte from the cipher core
//   in_valid   in   one-cycle pulse, in_data is a new byte
//   clr        in   synchronous flush, same effect as rst
//   out_data   out  [7:0] head byte, 0 while out_valid is low
//   out_valid  out  buffer holds at least one byte
//   out_ready  in   consumer takes the head byte this cycle
//   hold_off   out  count >= AFULL
//   count      out  [$clog2(DEPTH):0] stored bytes, 0..DEPTH
//   ovf        out  sticky, a byte was dropped since the last reset/flush
//   drop_cnt   out  [7:0] dropped bytes, saturating at 255

module trivium_out_buffer #(
  parameter int DEPTH = 16,
  parameter int AFULL = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  input  logic                     clr,
  output logic [7:0]               out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     hold_off,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf,
  output logic [7:0]               drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_FULL  = CW'(DEPTH);
  localparam logic [CW-1:0] C_AFULL = CW'(AFULL);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_PARTIAL,
    S_HOLD,
    S_FULL
  } state_t;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_ovf;
  logic [7:0]    r_drop_cnt;
  state_t        r_state;

  logic          w_flush;
  logic          w_rd;
  logic          w_wr;
  logic          w_drop;
  logic [CW-1:0] w_count_nxt;
  state_t        w_state_nxt;

  assign w_flush = rst | clr;
  assign w_rd    = (r_count != '0) && out_ready;
  // A full buffer still accepts a byte when the head leaves in the same cycle.
  assign w_wr    = in_valid && ((r_count != C_FULL) || w_rd);
  assign w_drop  = in_valid && (r_count == C_FULL) && !w_rd;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr, w_rd})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Occupancy band of the next count; count moves by at most one per cycle,
  // so the band can only step to a neighbour except on flush.
  always_comb begin
    w_state_nxt = S_PARTIAL;
    if (w_count_nxt == '0)
      w_state_nxt = S_EMPTY;
    else if (w_count_nxt == C_FULL)
      w_state_nxt = S_FULL;
    else if (w_count_nxt >= C_AFULL)
      w_state_nxt = S_HOLD;
  end

  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_ovf      <= 1'b0;
      r_drop_cnt <= 8'h00;
      r_state    <= S_EMPTY;
    end else begin
      if (w_wr)
        r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd)
        r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_nxt;
      r_state <= w_state_nxt;
      if (w_drop) begin
        r_ovf <= 1'b1;
        if (r_drop_cnt != 8'hFF)
          r_drop_cnt <= r_drop_cnt + 8'h01;
      end
    end
  end

  // Storage carries no reset; validity is defined solely by the pointers and count.
  always_ff @(posedge clk) begin
    if (!w_flush && w_wr)
      r_mem[r_wr_ptr] <= in_data;
  end

  assign out_valid = (r_count != '0);
  assign out_data  = out_valid ? r_mem[r_rd_ptr] : 8'h00;
  assign hold_off  = (r_state == S_HOLD) || (r_state == S_FULL);
  assign count     = r_count;
  assign ovf       = r_ovf;
  assign drop_cnt  = r_drop_cnt;

endmodule
